// File: rtl/lcd_bus_rx_if.sv
// lcd_bus_rx_if: 8080-style LCD write bus in, decoded pixel stream out
interface lcd_bus_rx_if #(
  parameter int X_W = 10,
  parameter int Y_W = 7
);
  logic [7:0]     i_lcd_data;
  logic           i_lcd_wr;
  logic           i_lcd_dc;
  logic           o_pix_valid;
  logic [X_W-1:0] o_pix_x;
  logic [Y_W-1:0] o_pix_y;
  logic [15:0]    o_pix_data;
  logic           o_frame_done;
  logic           o_err;
  modport master (
    output i_lcd_data, i_lcd_wr, i_lcd_dc,
    input  o_pix_valid, o_pix_x, o_pix_y, o_pix_data, o_frame_done, o_err
  );
  modport slave (
    input  i_lcd_data, i_lcd_wr, i_lcd_dc,
    output o_pix_valid, o_pix_x, o_pix_y, o_pix_data, o_frame_done, o_err
  );
endinterface

// File: rtl/lcd_bus_rx.sv
// lcd_bus_rx: decodes CASET/RASET/RAMWR from the LCD write bus into windowed RGB565 pixel strobes
module lcd_bus_rx #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 96,
  parameter int X_W      = 10,
  parameter int Y_W      = 7
) (
  input logic         i_clk,
  input logic         i_res_n,
  lcd_bus_rx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CASET, RASET, RAMWR, IGNORE} state_t;
  state_t         state_q;
  logic [7:0]     r_data_q, hi_q;
  logic           r_dc_q, r_wr_q, wr_prev_q, phase_q;
  logic [2:0]     pidx_q;
  logic [23:0]    p_q;
  logic [15:0]    xs_q, xe_q, ys_q, ye_q, x_q, y_q;
  logic           pix_valid_q, frame_done_q, err_q;
  logic [X_W-1:0] pix_x_q;
  logic [Y_W-1:0] pix_y_q;
  logic [15:0]    pix_data_q;
  logic           acc, x_last, y_last, in_range, win_ok;
  logic [15:0]    par_end;
  assign acc      = r_wr_q & ~wr_prev_q;
  assign x_last   = x_q == xe_q;
  assign y_last   = y_q == ye_q;
  assign in_range = x_q < 16'(H_ACTIVE) && y_q < 16'(V_ACTIVE);
  assign par_end  = {p_q[7:0], r_data_q};
  assign win_ok   = p_q[23:8] <= par_end;
  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state_q      <= IDLE;
      r_data_q     <= '0;
      r_dc_q       <= 1'b0;
      r_wr_q       <= 1'b0;
      wr_prev_q    <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      pidx_q       <= '0;
      p_q          <= '0;
      xs_q         <= '0;
      xe_q         <= 16'(H_ACTIVE - 1);
      ys_q         <= '0;
      ye_q         <= 16'(V_ACTIVE - 1);
      x_q          <= '0;
      y_q          <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= '0;
    end else begin
      r_data_q     <= bus.i_lcd_data;
      r_dc_q       <= bus.i_lcd_dc;
      r_wr_q       <= bus.i_lcd_wr;
      wr_prev_q    <= r_wr_q;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      if (acc && !r_dc_q) begin
        // a command abandons any half-received pixel
        pidx_q  <= '0;
        phase_q <= 1'b0;
        err_q   <= state_q == RAMWR && phase_q;
        state_q <= r_data_q == 8'h2A ? CASET :
                   r_data_q == 8'h2B ? RASET :
                   r_data_q == 8'h2C ? RAMWR : IGNORE;
        if (r_data_q == 8'h2C) begin
          x_q <= xs_q;
          y_q <= ys_q;
        end
      end else if (acc) begin
        case (state_q)
          CASET, RASET: begin
            if (pidx_q == 3'd4) err_q <= 1'b1;
            else begin
              p_q    <= {p_q[15:0], r_data_q};
              pidx_q <= pidx_q + 3'd1;
              if (pidx_q == 3'd3) begin
                if (!win_ok) err_q <= 1'b1;
                else if (state_q == CASET) begin
                  xs_q <= p_q[23:8];
                  xe_q <= par_end;
                end else begin
                  ys_q <= p_q[23:8];
                  ye_q <= par_end;
                end
              end
            end
          end
          RAMWR: begin
            phase_q <= ~phase_q;
            if (!phase_q) hi_q <= r_data_q;
            else begin
              pix_valid_q  <= in_range;
              pix_x_q      <= x_q[X_W-1:0];
              pix_y_q      <= y_q[Y_W-1:0];
              pix_data_q   <= {hi_q, r_data_q};
              frame_done_q <= x_last && y_last;
              x_q          <= x_last ? xs_q : x_q + 16'd1;
              y_q          <= !x_last ? y_q : y_last ? ys_q : y_q + 16'd1;
            end
          end
          IDLE: err_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end
  assign bus.o_pix_valid  = pix_valid_q;
  assign bus.o_pix_x      = pix_x_q;
  assign bus.o_pix_y      = pix_y_q;
  assign bus.o_pix_data   = pix_data_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_err        = err_q;
endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb_lcd_bus_rx: scoreboard bench; a raster model predicts every pixel/frame_done event and error count
module tb_lcd_bus_rx;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;
  lcd_bus_rx_if bus ();
  lcd_bus_rx dut (.i_clk(clk), .i_res_n(res_n), .bus(bus));
  typedef struct packed {
    logic        v;
    logic        fd;
    logic [9:0]  x;
    logic [6:0]  y;
    logic [15:0] d;
  } ev_t;
  ev_t q[$];
  int n_tests = 0, n_fail = 0, err_cnt = 0, exp_err = 0;
  logic [15:0] xs, xe, ys, ye, cx, cy;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    ev_t e;
    if (res_n) begin
      if (bus.o_err) err_cnt++;
      if (bus.o_pix_valid) check("err_with_pix", bus.o_err, 0);
      if (bus.o_pix_valid || bus.o_frame_done) begin
        if (q.size() == 0) check("unexpected_pix", q.size(), 1);
        else begin
          e = q.pop_front();
          if (e.v) check("pix", {bus.o_pix_valid, bus.o_frame_done, bus.o_pix_x, bus.o_pix_y, bus.o_pix_data}, e);
          else check("oor_frame_done", {bus.o_pix_valid, bus.o_frame_done}, {e.v, e.fd});
        end
      end
    end
  end
  task automatic send(input logic dc, input logic [7:0] b);
    @(posedge clk);
    #1 bus.i_lcd_data = b;
    bus.i_lcd_dc = dc;
    bus.i_lcd_wr = 1'b1;
    @(posedge clk);
    #1 bus.i_lcd_wr = 1'b0;
  endtask
  task automatic model_init();
    xs = 0; xe = 319; ys = 0; ye = 95; cx = 0; cy = 0;
  endtask
  task automatic cmd(input logic [7:0] b);
    send(1'b0, b);
    if (b == 8'h2C) begin
      cx = xs;
      cy = ys;
    end
  endtask
  task automatic win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    send(1'b0, c);
    send(1'b1, s[15:8]);
    send(1'b1, s[7:0]);
    send(1'b1, e[15:8]);
    send(1'b1, e[7:0]);
    if (s > e) exp_err++;
    else if (c == 8'h2A) begin
      xs = s; xe = e;
    end else begin
      ys = s; ye = e;
    end
  endtask
  task automatic expect_px(input logic [15:0] d);
    ev_t e;
    e.v  = cx < 320 && cy < 96;
    e.fd = cx == xe && cy == ye;
    e.x  = cx[9:0];
    e.y  = cy[6:0];
    e.d  = d;
    if (e.v || e.fd) q.push_back(e);
    if (cx != xe) cx = cx + 1;
    else begin
      cx = xs;
      cy = cy == ye ? ys : cy + 1;
    end
  endtask
  task automatic px(input logic [15:0] d);
    expect_px(d);
    send(1'b1, d[15:8]);
    send(1'b1, d[7:0]);
  endtask
  task automatic settle(input string tag);
    repeat (6) @(posedge clk);
    check({tag, "_drain"}, q.size(), 0);
    check({tag, "_err"}, err_cnt, exp_err);
  endtask
  task automatic check_zero(input string tag);
    check(tag, {bus.o_pix_valid, bus.o_pix_x, bus.o_pix_y, bus.o_pix_data, bus.o_frame_done, bus.o_err}, 0);
  endtask
  initial begin
    bus.i_lcd_data = 8'h00;
    bus.i_lcd_wr = 1'b0;
    bus.i_lcd_dc = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset_outs");
    res_n = 1'b1;
    model_init();
    send(1'b1, 8'h55);
    exp_err++;
    settle("idle_data");
    // large window: every column, last four rows, frame_done at (319,95)
    win(8'h2A, 16'd0, 16'd319);
    win(8'h2B, 16'd92, 16'd95);
    cmd(8'h2C);
    for (int i = 0; i < 1280; i++) px(16'($urandom));
    settle("raster");
    win(8'h2B, 16'd0, 16'd95);
    cmd(8'h2C);
    send(1'b1, 8'hF8);
    expect_px(16'hF800);
    @(posedge clk);
    #1 bus.i_lcd_data = 8'h00;
    bus.i_lcd_dc = 1'b1;
    bus.i_lcd_wr = 1'b1;
    @(posedge clk);
    #1 check("latency_1clk", bus.o_pix_valid, 0);
    bus.i_lcd_wr = 1'b0;
    @(posedge clk);
    #1 check("latency_2clk", bus.o_pix_valid, 1);
    px(16'h07E0);
    settle("first_pixels");
    win(8'h2A, 16'd5, 16'd6);
    win(8'h2B, 16'd2, 16'd3);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) px(16'hA000 + 16'(i));
    settle("small_window");
    win(8'h2A, 16'h0010, 16'h0005);
    cmd(8'h2C);
    px(16'h1111);
    settle("bad_caset");
    cmd(8'h2C);
    send(1'b1, 8'hAB);
    cmd(8'h2C);
    exp_err++;
    px(16'h1234);
    settle("dropped_hi");
    win(8'h2B, 16'd2, 16'd3);
    send(1'b1, 8'h00);
    exp_err++;
    settle("extra_param");
    cmd(8'h00);
    send(1'b1, 8'h77);
    settle("ignore_data");
    win(8'h2A, 16'd318, 16'd321);
    win(8'h2B, 16'd95, 16'd95);
    cmd(8'h2C);
    for (int i = 0; i < 4; i++) px(16'h5A00 + 16'(i));
    settle("out_of_range");
    win(8'h2A, 16'd0, 16'd319);
    win(8'h2B, 16'd0, 16'd95);
    cmd(8'h2C);
    for (int i = 0; i < 7; i++) px(16'h0100 + 16'(i));
    send(1'b1, 8'hCC);
    res_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("midframe_reset_outs");
    res_n = 1'b1;
    model_init();
    cmd(8'h2C);
    px(16'h0001);
    settle("after_reset");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
